// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: two-master to one-slave arbiter for the AXI read channels.
//   M0 = instruction fetch, M1 = data load. One read is in flight at a time.
//   The grant is locked from the AR handshake to the final R beat.
//
// Ports:
//   clk, rst               : single clock; synchronous active-low reset
//   mN_ar*                 : upstream AR channel from master N (N = 0, 1)
//   mN_r*                  : upstream R channel to master N
//   s_ar*                  : downstream AR; s_arid = {master index, mN_arid}
//   s_r*                   : downstream R; routed to the granted master
//   id_err                 : registered pulse, accepted beat whose upper ID
//                            bits do not match the granted master index
//
// Build option: AXI_RR_ARB_EN selects round-robin arbitration; otherwise
// fixed priority with M1 ahead of M0.
module axi_read_arbiter #(
  parameter int ID_W   = 4,
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   m0_arid,
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [LEN_W-1:0]  m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [ID_W-1:0]   m0_rid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  input  logic [ID_W-1:0]   m1_arid,
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [LEN_W-1:0]  m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [ID_W-1:0]   m1_rid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  output logic [IDS_W-1:0]  s_arid,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [LEN_W-1:0]  s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [IDS_W-1:0]  s_rid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic              s_rvalid,
  output logic              s_rready,
  output logic              id_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;
  logic   id_err_q, id_err_d;
  logic   pick;
  logic   sel_arvalid;

  assign id_err = id_err_q;

  // Arbitration winner among current requesters.
  always_comb begin
`ifdef AXI_RR_ARB_EN
    if (m0_arvalid && m1_arvalid) pick = ~last_grant_q;
    else                          pick = m1_arvalid;
`else
    pick = m1_arvalid;
`endif
  end

  // Datapath muxing, driven only from registered state and grant.
  always_comb begin
    sel_arvalid = grant_q ? m1_arvalid : m0_arvalid;
    s_arid      = '0;
    s_araddr    = '0;
    s_arlen     = '0;
    s_arsize    = '0;
    s_arburst   = '0;
    s_arvalid   = 1'b0;
    s_rready    = 1'b0;
    m0_arready  = 1'b0;
    m1_arready  = 1'b0;
    m0_rvalid   = 1'b0;
    m0_rid      = '0;
    m0_rdata    = '0;
    m0_rresp    = '0;
    m0_rlast    = 1'b0;
    m1_rvalid   = 1'b0;
    m1_rid      = '0;
    m1_rdata    = '0;
    m1_rresp    = '0;
    m1_rlast    = 1'b0;
    if (state_q == ADDR) begin
      s_arvalid = sel_arvalid;
      if (grant_q) begin
        s_arid     = {(IDS_W-ID_W)'(1'b1), m1_arid};
        s_araddr   = m1_araddr;
        s_arlen    = m1_arlen;
        s_arsize   = m1_arsize;
        s_arburst  = m1_arburst;
        m1_arready = s_arready;
      end else begin
        s_arid     = {(IDS_W-ID_W)'(1'b0), m0_arid};
        s_araddr   = m0_araddr;
        s_arlen    = m0_arlen;
        s_arsize   = m0_arsize;
        s_arburst  = m0_arburst;
        m0_arready = s_arready;
      end
    end else if (state_q == DATA) begin
      if (grant_q) begin
        m1_rvalid = s_rvalid;
        m1_rid    = s_rid[ID_W-1:0];
        m1_rdata  = s_rdata;
        m1_rresp  = s_rresp;
        m1_rlast  = s_rlast;
        s_rready  = m1_rready;
      end else begin
        m0_rvalid = s_rvalid;
        m0_rid    = s_rid[ID_W-1:0];
        m0_rdata  = s_rdata;
        m0_rresp  = s_rresp;
        m0_rlast  = s_rlast;
        s_rready  = m0_rready;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    id_err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          state_d = ADDR;
          grant_d = pick;
        end
      end
      ADDR: begin
        if (sel_arvalid && s_arready) begin
          state_d      = DATA;
          last_grant_d = grant_q;
        end else if (!sel_arvalid) begin
          // Requester withdrew before the handshake: drop the grant.
          state_d = IDLE;
        end
      end
      DATA: begin
        if (s_rvalid && s_rready) begin
          id_err_d = (s_rid[IDS_W-1:ID_W] != (IDS_W-ID_W)'(grant_q));
          if (s_rlast) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      id_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      id_err_q     <= id_err_d;
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: scoreboard bench for axi_read_arbiter. Expected AR and
// R transfers are queued when stimulus is driven and compared at handshakes.
module tb_axi_read_arbiter;

  logic        clk, rst;
  logic [3:0]  m0_arid, m1_arid, m0_rid, m1_rid;
  logic [31:0] m0_araddr, m1_araddr, m0_rdata, m1_rdata;
  logic [3:0]  m0_arlen, m1_arlen;
  logic [2:0]  m0_arsize, m1_arsize;
  logic [1:0]  m0_arburst, m1_arburst, m0_rresp, m1_rresp;
  logic        m0_arvalid, m1_arvalid, m0_arready, m1_arready;
  logic        m0_rlast, m1_rlast, m0_rvalid, m1_rvalid, m0_rready, m1_rready;
  logic [7:0]  s_arid, s_rid;
  logic [31:0] s_araddr, s_rdata;
  logic [3:0]  s_arlen;
  logic [2:0]  s_arsize;
  logic [1:0]  s_arburst, s_rresp;
  logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready, id_err;

  axi_read_arbiter #(.ID_W(4), .IDS_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) dut (
    .clk(clk), .rst(rst),
    .m0_arid(m0_arid), .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
    .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
    .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_arid(m1_arid), .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
    .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
    .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .id_err(id_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [63:0] ar_q[$];
  logic [63:0] r_q[$];
  int ar_hs, r_hs;
  int first, second;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Compare any handshake about to complete at the coming edge.
  task automatic monitor();
    logic [63:0] e;
    ar_hs = -1;
    r_hs  = -1;
    if (s_arvalid && s_arready) begin
      if (ar_q.size() == 0) check("ar_unexpected", 1, 0);
      else begin
        e = ar_q.pop_front();
        check("ar_fields", {s_arid, s_araddr, s_arlen, s_arsize, s_arburst}, e);
        check("ar_ready_route", {m1_arready, m0_arready}, e[45] ? 2'b10 : 2'b01);
        ar_hs = int'(e[45]);
      end
    end
    if (s_rvalid && s_rready) begin
      if (r_q.size() == 0) check("r_unexpected", 1, 0);
      else begin
        e = r_q.pop_front();
        check("r_beat", {m1_rvalid, m0_rvalid, m0_rid | m1_rid, m0_rdata | m1_rdata,
                         m0_rresp | m1_rresp, m0_rlast | m1_rlast}, e);
        r_hs = e[40] ? 1 : 0;
      end
    end
  endtask

  task automatic cyc();
    #1;
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int m, input logic [3:0] id, input logic [31:0] addr,
                     input logic [3:0] len);
    if (m == 0) begin
      m0_arid = id; m0_araddr = addr; m0_arlen = len; m0_arsize = 3'd2;
      m0_arburst = 2'b01; m0_arvalid = 1'b1;
    end else begin
      m1_arid = id; m1_araddr = addr; m1_arlen = len; m1_arsize = 3'd2;
      m1_arburst = 2'b01; m1_arvalid = 1'b1;
    end
    ar_q.push_back({15'd0, 4'(m), id, addr, len, 3'd2, 2'b01});
  endtask

  task automatic wait_ar(input int m);
    bit got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc();
      if (ar_hs == m) got = 1;
    end
    check("ar_handshake_seen", got, 1);
    if (m == 0) m0_arvalid = 1'b0;
    else        m1_arvalid = 1'b0;
  endtask

  task automatic beat(input int m, input logic [7:0] rid, input logic [31:0] data,
                      input logic last);
    bit got = 0;
    s_rvalid = 1'b1; s_rid = rid; s_rdata = data; s_rresp = 2'b00; s_rlast = last;
    r_q.push_back({23'd0, (m == 1) ? 2'b10 : 2'b01, rid[3:0], data, 2'b00, last});
    #1;
    check("no_ar_in_data", {s_arvalid, m1_arready, m0_arready}, 3'b000);
    for (int i = 0; i < 20 && !got; i++) begin
      cyc();
      if (r_hs == m) got = 1;
    end
    check("r_handshake_seen", got, 1);
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_s_ar"}, {s_arvalid, s_arid, s_araddr, s_arlen, s_arsize, s_arburst}, 0);
    check({tag, "_m0"}, {m0_arready, m0_rvalid, m0_rid, m0_rdata, m0_rresp, m0_rlast}, 0);
    check({tag, "_m1"}, {m1_arready, m1_rvalid, m1_rid, m1_rdata, m1_rresp, m1_rlast}, 0);
    check({tag, "_misc"}, {s_rready, id_err}, 0);
  endtask

  initial begin
    rst = 1'b0;
    {m0_arid, m0_araddr, m0_arlen, m0_arsize, m0_arburst, m0_arvalid} = '0;
    {m1_arid, m1_araddr, m1_arlen, m1_arsize, m1_arburst, m1_arvalid} = '0;
    {s_rid, s_rdata, s_rresp, s_rlast, s_rvalid} = '0;
    m0_rready = 1'b1; m1_rready = 1'b1; s_arready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_quiet("reset");
    rst = 1'b1;

    // Stray beat in IDLE is not accepted.
    s_rvalid = 1'b1; s_rlast = 1'b1;
    #1;
    check("idle_no_rready", {s_rready, m0_rvalid, m1_rvalid}, 0);
    cyc();
    s_rvalid = 1'b0; s_rlast = 1'b0;

    // Single M0 read, one-cycle AR latency.
    req(0, 4'h0, 32'h0000_1000, 4'd0);
    #1;
    check("ar_lat_idle", s_arvalid, 0);
    cyc();
    check("ar_lat_addr", {s_arvalid, s_arid, m1_arready}, {1'b1, 8'h00, 1'b0});
    wait_ar(0);
    beat(0, 8'h00, 32'hDEAD_BEEF, 1'b1);
    check("single_no_id_err", id_err, 0);

    // Tie from reset.
    rst = 1'b0; cyc(); rst = 1'b1;
`ifdef AXI_RR_ARB_EN
    first = 0;
`else
    first = 1;
`endif
    second = 1 - first;
    req(first, 4'h0, 32'h0000_2000, 4'd0);
    req(second, 4'h0, 32'h0000_3000, 4'd0);
    wait_ar(first);
    beat(first, {4'(first), 4'h0}, 32'h1111_1111, 1'b1);
    wait_ar(second);
    beat(second, {4'(second), 4'h0}, 32'h2222_2222, 1'b1);

    // Burst lock on M1 while M0 keeps requesting.
    req(1, 4'h7, 32'h0000_4000, 4'd3);
    wait_ar(1);
    req(0, 4'h2, 32'h0000_5000, 4'd0);
    for (int b = 0; b < 4; b++) beat(1, 8'h17, 32'h0000_00B0 + b, b == 3);
    #1;
    check("idle_bubble", {s_arvalid, m0_arready}, 0);
    cyc();
    check("m0_after_bubble", {s_arvalid, s_arid}, {1'b1, 8'h02});
    wait_ar(0);

    // Backpressure from M0 in DATA.
    m0_rready = 1'b0;
    s_rvalid = 1'b1; s_rid = 8'h02; s_rdata = 32'h0000_CAFE; s_rlast = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_stall", {s_rready, m0_rvalid}, 2'b01);
      cyc();
    end
    m0_rready = 1'b1;
    beat(0, 8'h02, 32'h0000_CAFE, 1'b1);

    // Upper ID mismatch.
    req(0, 4'h3, 32'h0000_6000, 4'd0);
    wait_ar(0);
    beat(0, 8'h13, 32'h0000_0BAD, 1'b1);
    check("id_err_pulse", id_err, 1);
    cyc();
    check("id_err_clear", id_err, 0);

    // Reset in the middle of a burst.
    req(0, 4'h1, 32'h0000_7000, 4'd3);
    wait_ar(0);
    beat(0, 8'h01, 32'h0000_0001, 1'b0);
    beat(0, 8'h01, 32'h0000_0002, 1'b0);
    s_rvalid = 1'b1; s_rid = 8'h01; s_rdata = 32'h0000_0003;
    m0_rready = 1'b0;
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    m0_rready = 1'b1;
    #1;
    check_quiet("midburst_rst");
    cyc();
    s_rvalid = 1'b0;
    req(1, 4'h4, 32'h0000_8000, 4'd1);
    wait_ar(1);
    beat(1, 8'h14, 32'h0000_0044, 1'b0);
    beat(1, 8'h14, 32'h0000_0045, 1'b1);

    check("ar_queue_drained", ar_q.size(), 0);
    check("r_queue_drained", r_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
